run_sequencer: RTL and testbench
================================

# run_sequencer

Run controller that sequences the single-cycle core through a start/finish handshake with the host. On `req` it holds the core in reset, releases it, and clock-enables it. It stops the core when the program counter reaches the halt address or a cycle budget expires, then raises `done`. It also owns the data-memory port select, so the host can load and read memory only while the core is idle or finished.

## Interface
Parameters:
- `PC_WIDTH`, 12: program-counter width.
- `HALT_PC`, 128: PC value that marks program completion.
- `RST_CYCLES`, 2: cycles the core reset is held after a start; legal range is 1 to 15.
- `TIMEOUT`, 4096: maximum number of core-enabled cycles per run; must be at least 1.
- `CNT_WIDTH`, 16: width of `cycle_count`; must be able to hold `TIMEOUT`.

Ports (clock and reset first):
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 1: host start request, level-sensitive, four-phase handshake with `done`.
- `prog_ctr`, in, `PC_WIDTH`: current core program counter.
- `core_reset`, out, 1: drives the core PC/flag reset.
- `core_run`, out, 1: core clock-enable for PC, reg_file, dat_mem write and flag registers.
- `host_sel`, out, 1: data-memory port select; 1 = host owns the port, 0 = core owns it.
- `busy`, out, 1: a run is in progress (PRIME or RUN).
- `done`, out, 1: run finished; held until `req` drops.
- `timeout`, out, 1: sticky; the last run ended by the cycle budget, not by halt.
- `cycle_count`, out, `CNT_WIDTH`: number of core-enabled cycles in the current or last run.

## Operation
- FSM states are IDLE, PRIME, RUN and DONE. It is a Moore decode except for the `core_run` halt gating.
- IDLE:
  - Outputs: `host_sel`=1, all other outputs 0; `cycle_count` and `timeout` hold the last run's values.
  - `req`=1 moves to PRIME and clears `cycle_count`, `timeout` and the prime counter.
- PRIME:
  - Outputs: `core_reset`=1, `busy`=1, `host_sel`=0, `core_run`=0.
  - Stays exactly `RST_CYCLES` cycles, then moves to RUN.
  - `req` is ignored here.
- RUN:
  - Outputs: `busy`=1, `host_sel`=0, `core_run` = (`prog_ctr` != `HALT_PC`).
  - Each edge with `core_run`=1 increments `cycle_count`.
  - Halt: if `prog_ctr` == `HALT_PC`, `core_run` is 0 in that same cycle (the core freezes) and the FSM moves to DONE; `cycle_count` does not increment.
  - Timeout: if `core_run`=1 and `cycle_count` == `TIMEOUT`-1, the count becomes `TIMEOUT`, `timeout` sets to 1, and the FSM moves to DONE.
  - Halt and timeout in the same cycle: halt wins, so `timeout` stays 0 and the count is unchanged.
  - Dropping `req` mid-run has no effect.
- DONE:
  - Outputs: `done`=1, `host_sel`=1, `core_run`=0, `core_reset`=0, so the core's registers are preserved for inspection.
  - `req`=0 moves to IDLE; `req` held at 1 stays in DONE, so there is no auto-restart.
- Reset:
  - Any state goes to IDLE on the next edge; the run is abandoned.
  - The core sees no `core_reset` from this block; the top-level reset covers the core.
- `cycle_count` never wraps, because it stops at `TIMEOUT`.

## Timing
- Reset values: state=IDLE, `core_reset`=0, `core_run`=0, `host_sel`=1, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0.
- Start: `req` sampled high at edge t in IDLE.
  - `core_reset`=1 during cycles t+1 through t+`RST_CYCLES`.
  - First `core_run`=1 cycle is t+`RST_CYCLES`+1.
- Halt: `prog_ctr` == `HALT_PC` in cycle k.
  - `core_run`=0 in cycle k (combinational).
  - `done`=1 from cycle k+1.
- Timeout: the `TIMEOUT`-th enabled cycle is cycle k; `done`=1 and `timeout`=1 from cycle k+1.
- Handshake: `done` falls one cycle after `req` is sampled low. A new `req` is accepted no earlier than the following edge.
- `host_sel` changes only on state edges and never glitches within a cycle.

## Test plan
- Reset, then `req`=1 with `RST_CYCLES`=2: `core_reset` is high for exactly 2 cycles, then `core_run`=1 and `busy`=1.
- PC model stepping +1 from 0 with `HALT_PC`=128: `core_run` drops in the cycle PC=128, `done`=1 the next cycle, `cycle_count`=128, `timeout`=0.
- PC model stuck in a loop, `TIMEOUT`=50: `done`=1 and `timeout`=1 after exactly 50 `core_run` cycles, `cycle_count`=50.
- Halt and timeout coincide (PC reaches 128 at `cycle_count`=`TIMEOUT`-1): `done`=1, `timeout`=0, `cycle_count`=`TIMEOUT`-1.
- `req` held high in DONE for 10 cycles: the FSM stays in DONE; `req`=0 gives IDLE the next cycle; `req`=1 again starts PRIME and clears `cycle_count` and `timeout`.
- `reset` asserted mid-RUN: IDLE on the next edge with all outputs at their reset values; `core_run`=0 and `host_sel`=1 from that edge.

Source files
------------

// File: rtl/run_sequencer.sv
// Run controller: primes the core with a reset pulse, clock-enables it until halt PC or cycle budget,
// then holds done until the host drops req. Data-memory port is handed to the host outside a run.
module run_sequencer #(
  parameter int PC_WIDTH   = 12,
  parameter int HALT_PC    = 128,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [PC_WIDTH-1:0]  prog_ctr,
  output logic                 core_reset,
  output logic                 core_run,
  output logic                 host_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [PC_WIDTH-1:0]  HALT       = PC_WIDTH'(HALT_PC);
  localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [3:0]           PRIME_LAST = 4'(RST_CYCLES - 1);

  state_t     state;
  logic [3:0] prime_cnt;
  logic       run_q;
  logic       at_halt;

  // The core must freeze in the very cycle it presents the halt PC, so this gate is combinational.
  assign at_halt  = (prog_ctr == HALT);
  assign core_run = run_q & ~at_halt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prime_cnt   <= '0;
      run_q       <= 1'b0;
      core_reset  <= 1'b0;
      host_sel    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= PRIME;
            prime_cnt   <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            core_reset  <= 1'b1;
            host_sel    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        PRIME: begin
          if (prime_cnt == PRIME_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            run_q      <= 1'b1;
          end else begin
            prime_cnt <= prime_cnt + 4'd1;
          end
        end
        RUN: begin
          if (at_halt) begin
            state    <= DONE;
            run_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            host_sel <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 1'b1;
            // Budget exhausted on this enabled cycle; halt already took priority above.
            if (cycle_count == LAST_CYCLE) begin
              timeout  <= 1'b1;
              state    <= DONE;
              run_q    <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              host_sel <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!req) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two instances (long budget / 50-cycle budget) driven by a simple PC model,
// checked every cycle against a behavioural model plus hand-computed literal expectations.
module tb_run_sequencer;
  localparam int RST  = 2;
  localparam int HALT = 128;
  localparam int TOA  = 4096;
  localparam int TOB  = 50;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        req [2];
  logic [11:0] pc [2];
  logic [11:0] pc_init [2];
  logic [11:0] pc_step [2];
  logic        core_reset [2];
  logic        core_run [2];
  logic        host_sel [2];
  logic        busy [2];
  logic        done [2];
  logic        timeout [2];
  logic [15:0] cycle_count [2];

  int checks = 0;
  int failures = 0;

  run_sequencer #(.PC_WIDTH(12), .HALT_PC(HALT), .RST_CYCLES(RST), .TIMEOUT(TOA), .CNT_WIDTH(16)) u_a (
    .clk(clk), .reset(reset[0]), .req(req[0]), .prog_ctr(pc[0]),
    .core_reset(core_reset[0]), .core_run(core_run[0]), .host_sel(host_sel[0]),
    .busy(busy[0]), .done(done[0]), .timeout(timeout[0]), .cycle_count(cycle_count[0]));

  run_sequencer #(.PC_WIDTH(12), .HALT_PC(HALT), .RST_CYCLES(RST), .TIMEOUT(TOB), .CNT_WIDTH(16)) u_b (
    .clk(clk), .reset(reset[1]), .req(req[1]), .prog_ctr(pc[1]),
    .core_reset(core_reset[1]), .core_run(core_run[1]), .host_sel(host_sel[1]),
    .busy(busy[1]), .done(done[1]), .timeout(timeout[1]), .cycle_count(cycle_count[1]));

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d expected=%0d at %0t", name, i, act, exp, $time);
    end
  endtask

  // Core stand-in: PC reloads while held in reset, advances by pc_step when enabled.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset[i] || core_reset[i]) pc[i] <= pc_init[i];
      else if (core_run[i]) pc[i] <= pc[i] + pc_step[i];
    end
  end

  // Behavioural model: phase 0 idle, 1 priming, 2 running, 3 finished.
  int m_phase [2] = '{0, 0};
  int m_age [2]   = '{0, 0};
  int m_cnt [2]   = '{0, 0};
  int m_to [2]    = '{0, 0};
  int m_budget [2] = '{TOA, TOB};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset[i]) begin
        m_phase[i] = 0; m_cnt[i] = 0; m_to[i] = 0;
      end else if (m_phase[i] == 0) begin
        if (req[i]) begin
          m_phase[i] = 1; m_age[i] = 0; m_cnt[i] = 0; m_to[i] = 0;
        end
      end else if (m_phase[i] == 1) begin
        m_age[i] = m_age[i] + 1;
        if (m_age[i] == RST) m_phase[i] = 2;
      end else if (m_phase[i] == 2) begin
        if (int'(pc[i]) == HALT) m_phase[i] = 3;
        else begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == m_budget[i]) begin
            m_to[i] = 1; m_phase[i] = 3;
          end
        end
      end else if (!req[i]) begin
        m_phase[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("core_reset", i, 32'(core_reset[i]), 32'(m_phase[i] == 1));
      chk("core_run",   i, 32'(core_run[i]),   32'(m_phase[i] == 2 && int'(pc[i]) != HALT));
      chk("host_sel",   i, 32'(host_sel[i]),   32'(m_phase[i] == 0 || m_phase[i] == 3));
      chk("busy",       i, 32'(busy[i]),       32'(m_phase[i] == 1 || m_phase[i] == 2));
      chk("done",       i, 32'(done[i]),       32'(m_phase[i] == 3));
      chk("timeout",    i, 32'(timeout[i]),    32'(m_to[i]));
      chk("cycle_count", i, 32'(cycle_count[i]), 32'(m_cnt[i]));
    end
  end

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (done[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", i, 32'(done[i]), 32'd1);
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rst_len;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; req[i] = 1'b0; pc_init[i] = 12'd0; pc_step[i] = 12'd1;
    end
    repeat (3) step_edge();
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(negedge clk);
    chk("rst_host_sel", 0, 32'(host_sel[0]), 32'd1);
    chk("rst_count", 0, 32'(cycle_count[0]), 32'd0);
    chk("rst_core_run", 0, 32'(core_run[0]), 32'd0);

    // Start on a: measure the core reset pulse, then run to halt at PC 128.
    step_edge();
    req[0] = 1'b1;
    rst_len = 0;
    for (int n = 0; n < 10 && core_run[0] !== 1'b1; n++) begin
      @(negedge clk);
      if (core_reset[0] === 1'b1) rst_len++;
    end
    chk("prime_len", 0, 32'(rst_len), 32'd2);
    chk("run_busy", 0, 32'(busy[0]), 32'd1);
    wait_done(0, 300);
    chk("halt_count", 0, 32'(cycle_count[0]), 32'd128);
    chk("halt_timeout", 0, 32'(timeout[0]), 32'd0);

    // req held in DONE: no restart; then full handshake and a fresh start.
    repeat (10) step_edge();
    @(negedge clk);
    chk("done_held", 0, 32'(done[0]), 32'd1);
    step_edge();
    req[0] = 1'b0;
    @(negedge clk);
    chk("done_before_edge", 0, 32'(done[0]), 32'd1);
    @(negedge clk);
    chk("idle_done", 0, 32'(done[0]), 32'd0);
    chk("idle_host", 0, 32'(host_sel[0]), 32'd1);
    step_edge();
    req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("restart_busy", 0, 32'(busy[0]), 32'd1);
    chk("restart_count", 0, 32'(cycle_count[0]), 32'd0);

    // Reset mid-run abandons the run.
    repeat (12) step_edge();
    reset[0] = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_run", 0, 32'(core_run[0]), 32'd0);
    chk("mid_rst_host", 0, 32'(host_sel[0]), 32'd1);
    chk("mid_rst_count", 0, 32'(cycle_count[0]), 32'd0);
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    step_edge();
    reset[0] = 1'b0;

    // b: PC stuck in a loop -> budget of 50 expires.
    pc_init[1] = 12'd5; pc_step[1] = 12'd0;
    step_edge();
    req[1] = 1'b1;
    wait_done(1, 100);
    chk("to_count", 1, 32'(cycle_count[1]), 32'd50);
    chk("to_flag", 1, 32'(timeout[1]), 32'd1);
    step_edge();
    req[1] = 1'b0;
    repeat (2) step_edge();

    // b: PC 79..127 uses 49 enabled cycles, halt arrives with count at budget-1.
    pc_init[1] = 12'd79; pc_step[1] = 12'd1;
    req[1] = 1'b1;
    wait_done(1, 100);
    chk("tie_count", 1, 32'(cycle_count[1]), 32'd49);
    chk("tie_timeout", 1, 32'(timeout[1]), 32'd0);
    step_edge();
    req[1] = 1'b0;
    repeat (3) step_edge();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
